// File: rtl/zjh_bcd_scan_counter_if.sv
// Purpose: groups the counter control, load, count and display pins of zjh_bcd_scan_counter.
// Latency: none; this is a wiring bundle only.
// Backpressure: none; En gates counting and there is no ready signal.
interface zjh_bcd_scan_counter_if #(
    parameter int NDIG = 4
);
    // Control and load inputs to the counter.
    logic                En;
    logic                Up;
    logic                Load;
    logic [4*NDIG-1:0]   Din;

    // Count state and cascade/status outputs.
    logic [4*NDIG-1:0]   Q;
    logic                C;
    logic                Err;

    // Display drive: one-hot digit select plus segments a..g.
    logic [NDIG-1:0]     Dig;
    logic                a;
    logic                b;
    logic                c;
    logic                d;
    logic                e;
    logic                f;
    logic                g;

    // Side that drives switches/enables and watches the display.
    modport master (
        output En, Up, Load, Din,
        input  Q, C, Err, Dig, a, b, c, d, e, f, g
    );

    // The counter itself.
    modport slave (
        input  En, Up, Load, Din,
        output Q, C, Err, Dig, a, b, c, d, e, f, g
    );
endinterface

// File: rtl/zjh_bcd_scan_counter.sv
// Purpose: N-digit BCD up/down counter with load, cascade carry and a multiplexed 7-segment scan.
// Latency: Q/Err update one Clk after the edge that samples them; C, Dig and segments are combinational.
// Backpressure: none; En is the only throttle and C is meant to feed the next stage's En.
module zjh_bcd_scan_counter #(
    parameter int NDIG           = 4,
    parameter int SCAN_DIV       = 4,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int LZB            = 0
) (
    input logic                   Clk,
    input logic                   MR,
    zjh_bcd_scan_counter_if.slave bus
);

    localparam int QW = 4 * NDIG;
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] PRESC_ONE = PW'(1);
    localparam logic [IW-1:0] IDX_MAX   = IW'(NDIG - 1);
    localparam logic [IW-1:0] IDX_ONE   = IW'(1);
    localparam logic [QW-1:0] ALL_NINES = {NDIG{4'h9}};

    // Active-high abcdefg pattern for one BCD digit; non-BCD values show nothing.
    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1111110;
            4'd1:    s = 7'b0110000;
            4'd2:    s = 7'b1101101;
            4'd3:    s = 7'b1111001;
            4'd4:    s = 7'b0110011;
            4'd5:    s = 7'b1011011;
            4'd6:    s = 7'b1011111;
            4'd7:    s = 7'b1110000;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1111011;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    // Registered state.
    logic [QW-1:0] q_q;
    logic [QW-1:0] q_d;
    logic          err_q;
    logic          err_d;
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic [IW-1:0] idx_q;
    logic [IW-1:0] idx_d;

    // Counter datapath intermediates.
    logic [QW-1:0] din_fix;
    logic          din_bad;
    logic [QW-1:0] cnt_next;
    logic          all_lower;
    logic [3:0]    dig_v;

    // Display intermediates.
    logic [NDIG-1:0] zero_from;
    logic            zero_run;
    logic [3:0]      cur_dig;
    logic            cur_blank;
    logic [NDIG-1:0] dig_sel;
    logic [6:0]      seg_raw;
    logic [6:0]      seg_out;
    logic [NDIG-1:0] dig_out;

    // Load sanitising: any non-BCD digit loads as zero and flags Err for the following cycle.
    always_comb begin
        din_fix = '0;
        din_bad = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (bus.Din[4*i +: 4] > 4'd9) begin
                din_bad = 1'b1;
            end else begin
                din_fix[4*i +: 4] = bus.Din[4*i +: 4];
            end
        end
    end

    // Ripple the count: a digit moves only when every lower digit sits at its wrap value.
    always_comb begin
        cnt_next  = q_q;
        all_lower = 1'b1;
        dig_v     = 4'd0;
        for (int i = 0; i < NDIG; i++) begin
            dig_v = q_q[4*i +: 4];
            if (all_lower) begin
                if (bus.Up) begin
                    cnt_next[4*i +: 4] = (dig_v == 4'd9) ? 4'd0 : dig_v + 4'd1;
                end else begin
                    cnt_next[4*i +: 4] = (dig_v == 4'd0) ? 4'd9 : dig_v - 4'd1;
                end
            end
            all_lower = all_lower & (bus.Up ? (dig_v == 4'd9) : (dig_v == 4'd0));
        end
    end

    // Next count state: Load beats En; Err is a one-cycle pulse, never held.
    always_comb begin
        q_d   = q_q;
        err_d = 1'b0;
        if (bus.Load) begin
            q_d   = din_fix;
            err_d = din_bad;
        end else if (bus.En) begin
            q_d = cnt_next;
        end
    end

    // Scan timing runs freely from Clk, independent of counting and loading.
    always_comb begin
        presc_d = presc_q + PRESC_ONE;
        idx_d   = idx_q;
        if (presc_q == PRESC_MAX) begin
            presc_d = '0;
            idx_d   = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_ONE;
        end
    end

    // All state registers; MR wins over everything and clears count, Err and scan position.
    always_ff @(posedge Clk) begin
        if (MR) begin
            q_q     <= '0;
            err_q   <= 1'b0;
            presc_q <= '0;
            idx_q   <= '0;
        end else begin
            q_q     <= q_d;
            err_q   <= err_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
        end
    end

    // zero_from[k] is set when digits k..NDIG-1 are all zero (leading-zero detection).
    always_comb begin
        zero_from = '0;
        zero_run  = 1'b1;
        for (int k = NDIG - 1; k >= 0; k--) begin
            zero_run     = zero_run & (q_q[4*k +: 4] == 4'd0);
            zero_from[k] = zero_run;
        end
    end

    // Pick the digit under the scan index and decide whether it is a blanked leading zero.
    always_comb begin
        dig_sel   = '0;
        cur_dig   = 4'd0;
        cur_blank = 1'b0;
        for (int k = 0; k < NDIG; k++) begin
            if (idx_q == IW'(k)) begin
                dig_sel[k] = 1'b1;
                cur_dig    = q_q[4*k +: 4];
                cur_blank  = (LZB != 0) && (k > 0) && zero_from[k];
            end
        end
    end

    // Segment pattern, blanking first, then polarity for common-anode boards.
    always_comb begin
        seg_raw = cur_blank ? 7'b0000000 : seg_decode(cur_dig);
        seg_out = seg_raw;
        dig_out = dig_sel;
        if (SEG_ACTIVE_LOW != 0) begin
            seg_out = ~seg_raw;
            dig_out = ~dig_sel;
        end
    end

    // Carry fires in the cycle before the wrap so the next stage counts on the same edge.
    assign bus.C = bus.En & ~bus.Load & ~MR &
                   ((bus.Up & (q_q == ALL_NINES)) | (~bus.Up & (q_q == '0)));

    assign bus.Q   = q_q;
    assign bus.Err = err_q;
    assign bus.Dig = dig_out;
    assign {bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g} = seg_out;

endmodule
